gearbox_upsizing_2x: RTL and testbench

- AXI-Stream width-upsizing gearbox.
- Packs two consecutive half-width input beats into one full-width output beat, halving the beat rate.
- Sits between a narrow producer and a wide consumer on a single clock domain.
- Both ports use an nb-bit tdata bus for uniform wiring; only the low half of in_tdata carries payload.

---
 rtl/gearbox_upsizing_2x.sv | 66 ++++++
 tb/tb_gearbox_upsizing_2x.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gearbox_upsizing_2x.sv
// AXI-Stream 2:1 width upsizer: two half-width input beats pack into one
// full-width output word, first beat in the low half.
module gearbox_upsizing_2x #(
  parameter int n = 5
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic [n*8-1:0] in_tdata,
  input  logic           in_tvalid,
  output logic           in_tready,
  output logic [n*8-1:0] out_tdata,
  output logic           out_tvalid,
  input  logic           out_tready
);
  localparam int nb   = n * 8;
  localparam int HALF = nb / 2;

  typedef enum logic {PH_EMPTY = 1'b0, PH_HALF = 1'b1} phase_e;

  phase_e            phase_q, phase_d;
  logic [HALF-1:0]   hold_q, hold_d;
  logic [nb-1:0]     tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              in_acc;

  // First halves never stall; a second half only waits on a full, stalled output.
  assign in_tready  = (phase_q == PH_EMPTY) || !tvalid_q || out_tready;
  assign in_acc     = in_tvalid && in_tready;
  assign out_tdata  = tdata_q;
  assign out_tvalid = tvalid_q;

  always_comb begin
    phase_d  = phase_q;
    hold_d   = hold_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    if (tvalid_q && out_tready)
      tvalid_d = 1'b0;
    if (in_acc) begin
      if (phase_q == PH_EMPTY) begin
        hold_d  = in_tdata[HALF-1:0];
        phase_d = PH_HALF;
      end else begin
        // A load on a draining edge overrides the clear above: no bubble.
        tdata_d  = {in_tdata[HALF-1:0], hold_q};
        tvalid_d = 1'b1;
        phase_d  = PH_EMPTY;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase_q  <= PH_EMPTY;
      hold_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      hold_q   <= hold_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end

endmodule

// File: tb/tb_gearbox_upsizing_2x.sv
// Scoreboard bench for gearbox_upsizing_2x: pairs of accepted input halves
// form expected words, checked in order against output handshakes.
module tb_gearbox_upsizing_2x;
  localparam int N    = 5;
  localparam int NB   = N * 8;
  localparam int HALF = NB / 2;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [NB-1:0] in_tdata = '0;
  logic          in_tvalid = 1'b0;
  logic          in_tready;
  logic [NB-1:0] out_tdata;
  logic          out_tvalid;
  logic          out_tready = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  logic [NB-1:0]   sb_q[$];
  logic [HALF-1:0] m_half;
  logic            m_has = 1'b0;
  logic            prev_stall = 1'b0;
  logic [NB-1:0]   prev_data;
  logic [NB-1:0]   last_out = '0;
  int              cnt_vld = 0;
  int              cnt_out = 0;
  logic            rnd_done = 1'b0;

  gearbox_upsizing_2x #(.n(N)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Model + monitor, sampled mid-cycle while all signals are settled.
  always @(negedge aclk) begin
    if (!aresetn) begin
      m_has      = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stable_vld", {63'd0, out_tvalid}, 64'd1);
        chk("stable_dat", {24'd0, out_tdata}, {24'd0, prev_data});
      end
      if (out_tvalid) cnt_vld++;
      if (out_tvalid && out_tready) begin
        cnt_out++;
        last_out = out_tdata;
        if (sb_q.size() == 0) chk("sb_empty", {24'd0, out_tdata}, 64'd0 - 64'd1);
        else chk("sb_word", {24'd0, out_tdata}, {24'd0, sb_q.pop_front()});
      end
      if (in_tvalid && in_tready) begin
        if (m_has) begin
          sb_q.push_back({in_tdata[HALF-1:0], m_half});
          m_has = 1'b0;
        end else begin
          m_half = in_tdata[HALF-1:0];
          m_has  = 1'b1;
        end
      end
      prev_stall = out_tvalid && !out_tready;
      prev_data  = out_tdata;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [NB-1:0] d);
    int t;
    t = 0;
    in_tvalid = 1'b1;
    in_tdata  = d;
    @(negedge aclk);
    while (!in_tready && t < 200) begin
      @(negedge aclk);
      t++;
    end
    if (!in_tready) chk("send_timeout", 64'd0, 64'd1);
    @(posedge aclk); #1;
    in_tvalid = 1'b0;
  endtask

  task automatic idle(input int c);
    repeat (c) @(posedge aclk);
    #1;
  endtask

  initial begin
    int base;
    int t;
    // 1. reset and idle
    #100;
    chk("rst_vld", {63'd0, out_tvalid}, 64'd0);
    chk("rst_dat", {24'd0, out_tdata}, 64'd0);
    chk("rst_rdy", {63'd0, in_tready}, 64'd1);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("idle_vld", {63'd0, out_tvalid}, 64'd0);
    end
    @(posedge aclk); #1;

    // 2. direct pair
    base = cnt_vld;
    send_beat(40'h00000_12345);
    send_beat(40'h00000_ABCDE);
    idle(5);
    chk("pair_word", {24'd0, last_out}, 64'hAB_CDE1_2345);
    chk("pair_vld_cycles", cnt_vld - base, 1);

    // 3. backpressure
    out_tready = 1'b0;
    send_beat(40'h00000_AAAAA);
    send_beat(40'h00000_BBBBB);
    send_beat(40'h00000_11111);
    in_tvalid = 1'b1;
    in_tdata  = 40'h00000_22222;
    repeat (3) begin
      @(negedge aclk);
      chk("bp_rdy", {63'd0, in_tready}, 64'd0);
      chk("bp_vld", {63'd0, out_tvalid}, 64'd1);
    end
    @(posedge aclk); #1;
    out_tready = 1'b1;
    @(negedge aclk);
    chk("bp_rdy_rise", {63'd0, in_tready}, 64'd1);
    @(posedge aclk); #1;
    in_tvalid = 1'b0;
    @(negedge aclk);
    chk("bp_next_vld", {63'd0, out_tvalid}, 64'd1);
    chk("bp_next_dat", {24'd0, out_tdata}, 64'h22_2221_1111);
    idle(3);
    chk("bp_last", {24'd0, last_out}, 64'h22_2221_1111);

    // 4. upper half ignored
    send_beat(40'hFFFFF_00001);
    send_beat(40'hFFFFF_00002);
    idle(3);
    chk("upper_ignore", {24'd0, last_out}, 64'h00_0020_0001);

    // 5. mid-pair reset
    send_beat(40'h00000_99999);
    aresetn = 1'b0;
    #20;
    chk("mid_rst_vld", {63'd0, out_tvalid}, 64'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    send_beat(40'h00000_00003);
    send_beat(40'h00000_00004);
    idle(3);
    chk("mid_rst_word", {24'd0, last_out}, 64'h00_0040_0003);

    // 6. random stream
    base = cnt_out;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          send_beat({$urandom(), $urandom()});
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge aclk); #1;
          out_tready = ($urandom_range(0, 2) != 0);
        end
        out_tready = 1'b1;
      end
    join
    t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      idle(1);
      t++;
    end
    idle(2);
    chk("rnd_outputs", cnt_out - base, 500);
    chk("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
